// File: rtl/axis2fifo_pkg.sv
// rtl/axis2fifo_pkg.sv - shared types and helpers for the AXIS-to-FIFO pixel packer
// Contents: capture FSM state enum, default lane/frame geometry, lane slice helper.
package axis2fifo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PACK = 1'b1
   } state_e;

   // Geometry for the default build (128-bit words, 32-bit pixels, 1280x1024 frame)
   localparam int DEF_FDW   = 128;
   localparam int DEF_ADW   = 32;
   localparam int R         = DEF_FDW / DEF_ADW;
   localparam int FRAME_PIX = 1280 * 1024;

   // MSB index of lane 'lane' in a word; lane 0 sits in the top bits
   function automatic int lane_msb(input int fdw, input int adw, input int lane);
      return fdw - 1 - lane * adw;
   endfunction

endpackage

// File: rtl/axis2fifo_pack_pix_packer.sv
// rtl/axis2fifo_pack_pix_packer.sv - lane counter, assembly buffer and byte masking
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pix_en_i        a captured pixel is presented this cycle
//   restart_i       pixel starts a new word at lane 0, discarding any partial assembly
//   flush_i         the word completes with this pixel; buffer and lane return to empty
//   pix_i, strb_i   pixel data and byte qualifiers
//   word_o          assembly buffer merged with the current pixel (what gets loaded on flush)
//   last_lane_o     current pixel lands in the last lane of the word
// Configuration: AXIS2FIFO_STRB_MASK_EN zeroes pixel bytes whose strobe bit is low.
module axis2fifo_pack_pix_packer
   import axis2fifo_pkg::*;
#(
   parameter int FDW = 128,
   parameter int ADW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en_i,
   input  logic             restart_i,
   input  logic             flush_i,
   input  logic [ADW-1:0]   pix_i,
   input  logic [ADW/8-1:0] strb_i,
   output logic [FDW-1:0]   word_o,
   output logic             last_lane_o
);

   localparam int LANES = FDW / ADW;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LW-1:0]  lane_q;
   logic [LW-1:0]  lane_eff;
   logic [FDW-1:0] buf_q;
   logic [FDW-1:0] merged;
   logic [ADW-1:0] pix_m;

`ifdef AXIS2FIFO_STRB_MASK_EN
   always_comb begin
      pix_m = pix_i;
      for (int b = 0; b < ADW / 8; b++) begin
         if (!strb_i[b]) pix_m[b*8 +: 8] = 8'h00;
      end
   end
`else
   logic unused_strb;
   assign unused_strb = ^strb_i;
   assign pix_m       = pix_i;
`endif

   // A restart pixel ignores whatever is half-assembled
   assign lane_eff    = restart_i ? '0 : lane_q;
   assign last_lane_o = (lane_eff == LW'(LANES - 1));

   always_comb begin
      merged = restart_i ? '0 : buf_q;
      for (int l = 0; l < LANES; l++) begin
         if (lane_eff == LW'(l)) merged[lane_msb(FDW, ADW, l) -: ADW] = pix_m;
      end
   end

   assign word_o = merged;

   // Buffer is cleared after every flush so a short (TLAST) word has zero-filled lanes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
         buf_q  <= '0;
      end else if (pix_en_i) begin
         if (flush_i) begin
            lane_q <= '0;
            buf_q  <= '0;
         end else begin
            lane_q <= lane_eff + LW'(1);
            buf_q  <= merged;
         end
      end
   end

endmodule

// File: rtl/axis2fifo_pack.sv
// rtl/axis2fifo_pack.sv - frame-aligned AXIS pixel packer feeding the forward write FIFO
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESETN   clock, asynchronous active-low reset
//   S_AXIS_T*/S_AXIS_USER         pixel stream in (TLAST = end of line, USER = start of frame)
//   cap_en                        arm capture of the frame whose SOF is accepted next
//   fwr_vld/fwr_dout/fwr_full     FIFO write port; a write happens on fwr_vld & !fwr_full
//   busy                          frame capture in progress
//   frame_done                    pulse with the last word of a frame entering the output reg
//   err_sof                       sticky flag: SOF arrived mid-frame
// Configuration: AXIS2FIFO_STRB_MASK_EN enables TSTRB byte masking inside the packer.
module axis2fifo_pack
   import axis2fifo_pkg::*;
#(
   parameter int FDW               = 128,
   parameter int AXIS_DATA_WIDTH   = 32,
   parameter int PIXELS_HORIZONTAL = 1280,
   parameter int PIXELS_VERTICAL   = 1024
) (
   input  logic                         S_AXIS_ACLK,
   input  logic                         S_AXIS_ARESETN,
   input  logic                         S_AXIS_TVALID,
   output logic                         S_AXIS_TREADY,
   input  logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                         S_AXIS_TLAST,
   input  logic                         S_AXIS_USER,
   input  logic                         cap_en,
   output logic                         fwr_vld,
   output logic [FDW-1:0]               fwr_dout,
   input  logic                         fwr_full,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         err_sof
);

   localparam int FRAME_PIXELS = PIXELS_HORIZONTAL * PIXELS_VERTICAL;
   localparam int CW           = $clog2(FRAME_PIXELS + 1);

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   logic           fwr_vld_q;
   logic [FDW-1:0] fwr_dout_q;
   logic           frame_done_q;
   logic           err_sof_q;

   logic           accept;
   logic           capture;
   logic           restart;
   logic           frame_end;
   logic           word_done;
   logic           last_lane;
   logic [FDW-1:0] word;

   // Ready whenever the output reg is empty or being drained this cycle, so a new
   // word can never overwrite one that has not reached the FIFO.
   assign S_AXIS_TREADY = S_AXIS_ARESETN & ~(fwr_vld_q & fwr_full);
   assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

   // Beats outside a frame are dropped unless they are an armed SOF
   assign capture = accept & ((state_q == PACK) | (S_AXIS_USER & cap_en));
   assign restart = capture & S_AXIS_USER;

   always_comb begin
      cnt_d = restart ? CW'(1) : cnt_q + CW'(1);
   end

   // Frame end wins over TLAST in the same beat; either way a single word is flushed
   assign frame_end = capture & (cnt_d == CW'(FRAME_PIXELS));
   assign word_done = capture & (last_lane | S_AXIS_TLAST | frame_end);

   axis2fifo_pack_pix_packer #(
      .FDW (FDW),
      .ADW (AXIS_DATA_WIDTH)
   ) u_packer (
      .clk         (S_AXIS_ACLK),
      .rst_n       (S_AXIS_ARESETN),
      .pix_en_i    (capture),
      .restart_i   (restart),
      .flush_i     (word_done),
      .pix_i       (S_AXIS_TDATA),
      .strb_i      (S_AXIS_TSTRB),
      .word_o      (word),
      .last_lane_o (last_lane)
   );

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fwr_vld_q    <= 1'b0;
         fwr_dout_q   <= '0;
         frame_done_q <= 1'b0;
         err_sof_q    <= 1'b0;
      end else begin
         frame_done_q <= frame_end;

         if (capture) begin
            cnt_q   <= frame_end ? '0 : cnt_d;
            state_q <= frame_end ? IDLE : PACK;
         end

         if (accept && state_q == PACK && S_AXIS_USER) err_sof_q <= 1'b1;

         // Load has priority; draining only clears valid, data holds its last value
         if (word_done) begin
            fwr_vld_q  <= 1'b1;
            fwr_dout_q <= word;
         end else if (fwr_vld_q && !fwr_full) begin
            fwr_vld_q  <= 1'b0;
         end
      end
   end

   assign fwr_vld    = fwr_vld_q;
   assign fwr_dout   = fwr_dout_q;
   assign busy       = (state_q == PACK);
   assign frame_done = frame_done_q;
   assign err_sof    = err_sof_q;

endmodule
